// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampled UART receiver with a start-bit glitch filter, mid-bit data
// sampling, stop-bit check, a one-clock done strobe and a frame-error flag.
module uart_rx_os #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [4:0]    SB_LAST  = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] BIT_LAST = NW'(DBIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q;
    logic            rx_meta_q, rx_s_q;
    logic [4:0]      s_cnt_q;
    logic [NW-1:0]   n_cnt_q;
    logic [DBIT-1:0] b_reg_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            s_cnt_q      <= '0;
            n_cnt_q      <= '0;
            b_reg_q      <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            rx_done_tick <= 1'b0;
            case (state_q)
                IDLE: if (!rx_s_q) begin
                    state_q <= START;
                    s_cnt_q <= '0;
                end
                // Half a bit into the start bit: a line back high means it was a glitch
                START: if (s_tick) begin
                    if (s_cnt_q == 5'd7) begin
                        state_q <= rx_s_q ? IDLE : DATA;
                        s_cnt_q <= '0;
                        n_cnt_q <= '0;
                    end else begin
                        s_cnt_q <= s_cnt_q + 5'd1;
                    end
                end
                DATA: if (s_tick) begin
                    if (s_cnt_q == 5'd15) begin
                        b_reg_q <= {rx_s_q, b_reg_q[DBIT-1:1]};
                        s_cnt_q <= '0;
                        if (n_cnt_q == BIT_LAST) state_q <= STOP;
                        else n_cnt_q <= n_cnt_q + 1'b1;
                    end else begin
                        s_cnt_q <= s_cnt_q + 5'd1;
                    end
                end
                STOP: if (s_tick) begin
                    if (s_cnt_q == SB_LAST) begin
                        state_q      <= IDLE;
                        dout         <= b_reg_q;
                        frame_err    <= ~rx_s_q;
                        rx_done_tick <= 1'b1;
                    end else begin
                        s_cnt_q <= s_cnt_q + 5'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed frames against two receivers (1 stop bit and 2 stop bits),
// tick every 4 clk, transmitter paced in ticks so tick stalls stretch the line too.
module tb_uart_rx_os;
    logic       clk = 1'b0, reset = 1'b1, rx = 1'b1, rx2 = 1'b1, s_tick = 1'b0, tick_en = 1'b1;
    logic [7:0] dout, dout2;
    logic       done, done2, fe, fe2;
    int         cyc = 0, checks = 0, errors = 0;
    int         t1, t6, t;
    logic [7:0] q_d[$], q2_d[$];
    logic       q_fe[$], q2_fe[$];
    int         q_t[$], q2_t[$];

    uart_rx_os #(.DBIT(8), .SB_TICK(16)) dut (
        .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
        .dout(dout), .rx_done_tick(done), .frame_err(fe));
    uart_rx_os #(.DBIT(8), .SB_TICK(32)) dut2 (
        .clk(clk), .reset(reset), .rx(rx2), .s_tick(s_tick),
        .dout(dout2), .rx_done_tick(done2), .frame_err(fe2));

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        cyc++;
        s_tick = tick_en && (cyc % 4 == 0);
    end

    always @(negedge clk) begin
        if (done) begin q_d.push_back(dout); q_fe.push_back(fe); q_t.push_back(cyc); end
        if (done2) begin q2_d.push_back(dout2); q2_fe.push_back(fe2); q2_t.push_back(cyc); end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
        checks++;
        assert (v >= lo && v <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, v, lo, hi);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (s_tick) k++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit two, input logic v);
        if (two) rx2 = v;
        else rx = v;
    endtask

    task automatic send(input bit two, input logic [7:0] d, input logic stop_val,
                        input int stop_ticks, input int stall_bit, output int t0);
        drive(two, 1'b0);
        t0 = cyc;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            drive(two, d[i]);
            if (i == stall_bit) begin
                wait_ticks(8);
                tick_en = 1'b0;
                idle(100);
                tick_en = 1'b1;
                wait_ticks(8);
            end else begin
                wait_ticks(16);
            end
        end
        drive(two, stop_val);
        wait_ticks(stop_ticks);
        drive(two, 1'b1);
    endtask

    task automatic wait_done(input bit two, input int n);
        int k = 0;
        while ((two ? q2_d.size() : q_d.size()) < n && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("done_wait", 32'((two ? q2_d.size() : q_d.size()) >= n), 32'd1);
    endtask

    initial begin
        idle(4);
        reset = 1'b0;
        idle(2);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_fe", 32'(fe), 32'h0);
        chk("rst_dout2", 32'(dout2), 32'h0);
        chk("rst_done2", 32'(done2), 32'h0);
        chk("rst_fe2", 32'(fe2), 32'h0);

        send(1'b0, 8'h55, 1'b1, 16, -1, t1);
        wait_done(1'b0, 1);
        idle(50);
        chk("s1_dout", 32'(q_d[0]), 32'h55);
        chk("s1_fe", 32'(q_fe[0]), 32'h0);
        chk("s1_port_dout", 32'(dout), 32'h55);
        chk("s1_count", 32'(q_d.size()), 32'd1);
        chk_rng("s1_latency", q_t[0] - t1, 600, 620);

        send(1'b0, 8'hA3, 1'b0, 12, -1, t);
        wait_done(1'b0, 2);
        idle(300);
        chk("s2_count", 32'(q_d.size()), 32'd2);
        chk("s2_dout", 32'(q_d[1]), 32'hA3);
        chk("s2_fe", 32'(q_fe[1]), 32'h1);

        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        idle(300);
        chk("s3_count", 32'(q_d.size()), 32'd2);
        chk("s3_dout_hold", 32'(dout), 32'hA3);
        chk("s3_fe_hold", 32'(fe), 32'h1);

        send(1'b0, 8'h00, 1'b1, 16, -1, t);
        send(1'b0, 8'hFF, 1'b1, 16, -1, t);
        wait_done(1'b0, 4);
        idle(50);
        chk("s4_count", 32'(q_d.size()), 32'd4);
        chk("s4_dout_a", 32'(q_d[2]), 32'h00);
        chk("s4_dout_b", 32'(q_d[3]), 32'hFF);
        chk("s4_fe_a", 32'(q_fe[2]), 32'h0);
        chk("s4_fe_b", 32'(q_fe[3]), 32'h0);
        chk_rng("s4_spacing", q_t[3] - q_t[2], 630, 650);

        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0);
            wait_ticks(16);
        end
        rx = 1'b0;
        wait_ticks(8);
        reset = 1'b1;
        rx = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(300);
        chk("s5_dout_cleared", 32'(dout), 32'h0);
        chk("s5_fe_cleared", 32'(fe), 32'h0);
        chk("s5_no_done", 32'(q_d.size()), 32'd4);
        send(1'b0, 8'h3C, 1'b1, 16, -1, t);
        wait_done(1'b0, 5);
        idle(100);
        chk("s5_count", 32'(q_d.size()), 32'd5);
        chk("s5_dout", 32'(q_d[4]), 32'h3C);
        chk("s5_fe", 32'(q_fe[4]), 32'h0);

        send(1'b1, 8'h7E, 1'b1, 32, 3, t6);
        wait_done(1'b1, 1);
        idle(50);
        chk("s6_dout", 32'(q2_d[0]), 32'h7E);
        chk("s6_fe", 32'(q2_fe[0]), 32'h0);
        chk("s6_count", 32'(q2_d.size()), 32'd1);
        chk_rng("s6_latency", q2_t[0] - t6, 765, 790);
        chk_rng("s6_vs_s1", (q2_t[0] - t6) - (q_t[0] - t1), 156, 172);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
